sdram_init_ref_sched: RTL and testbench

Command sequencer for the SDRAM command bus. It runs the power-up sequence: NOP wait, PRECHARGE-ALL, NUM_AREF AUTO-REFRESHes, then LOAD MODE. It then raises init_done. After init it runs a periodic refresh timer and borrows the command bus from the main transfer controller through a req/gnt handshake.

---
 rtl/sdram_init_ref_sched.sv | 247 ++++++++++++++++++++++++
 tb/tb_sdram_init_ref_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_ref_sched.sv
// -----------------------------------------------------------------------------
// sdram_init_ref_sched
//
// Drives the SDRAM command bus through the power-up sequence (NOP wait,
// PRECHARGE-ALL, NUM_AREF AUTO-REFRESHes, LOAD MODE), then raises init_done.
// After init it keeps a periodic refresh timer. Pending refreshes are counted
// in a 3-bit saturating counter and served by borrowing the command bus from
// the main transfer controller through ref_req / ref_gnt.
//
// Ports
//   sdram_clk     in   clock
//   sdram_resetn  in   asynchronous active-low reset
//   ref_gnt       in   main controller has released the bus
//   init_done     out  init complete, sticky until reset
//   ref_req       out  refresh pending, bus requested
//   ref_done      out  one-cycle pulse when a refresh completes
//   cmd_own       out  this block owns the SDRAM command bus
//   sdr_cs_n      out  chip select (always asserted)
//   sdr_ras_n     out  RAS
//   sdr_cas_n     out  CAS
//   sdr_we_n      out  WE
//   sdr_ba        out  bank address (always 0)
//   sdr_addr      out  address: bit10 for PRECHARGE-ALL, MODE_REG for LOAD MODE
//   ref_ovf       out  sticky: pending refresh counter saturated
// -----------------------------------------------------------------------------
module sdram_init_ref_sched #(
    parameter int                INIT_WAIT    = 500,
    parameter int                TRP          = 2,
    parameter int                TRFC         = 7,
    parameter int                TMRD         = 2,
    parameter int                NUM_AREF     = 2,
    parameter int                REF_INTERVAL = 780,
    parameter int                ADDR_W       = 13,
    parameter logic [ADDR_W-1:0] MODE_REG     = ADDR_W'('h033)
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              ref_gnt,
    output logic              init_done,
    output logic              ref_req,
    output logic              ref_done,
    output logic              cmd_own,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [1:0]        sdr_ba,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic              ref_ovf
);

    // {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CMD_NOP = 3'b111,
        CMD_PRE = 3'b010,
        CMD_REF = 3'b001,
        CMD_MRS = 3'b000
    } cmd_t;

    // Each command state means "that command is on the bus this cycle";
    // the matching _W state is the gap that follows it.
    typedef enum logic [3:0] {
        S_WAIT, S_PRE, S_PRE_W, S_AREF, S_AREF_W, S_MRS, S_MRS_W,
        S_IDLE, S_REQ, S_RPRE, S_RPRE_W, S_RAREF, S_RAREF_W
    } state_t;

    localparam int MAX_A   = (INIT_WAIT > TRP) ? INIT_WAIT : TRP;
    localparam int MAX_B   = (TRFC > TMRD) ? TRFC : TMRD;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int AREF_W  = $clog2(NUM_AREF + 1);
    localparam int TMR_W   = $clog2(REF_INTERVAL + 1);

    localparam logic [CNT_W-1:0]  C_INIT_WAIT = CNT_W'(INIT_WAIT);
    localparam logic [CNT_W-1:0]  C_TRP       = CNT_W'(TRP);
    localparam logic [CNT_W-1:0]  C_TRFC      = CNT_W'(TRFC);
    localparam logic [CNT_W-1:0]  C_TMRD      = CNT_W'(TMRD);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
    localparam logic [AREF_W-1:0] C_AREF_LAST = AREF_W'(NUM_AREF - 1);
    localparam logic [AREF_W-1:0] C_AREF_ONE  = AREF_W'(1);
    localparam logic [TMR_W-1:0]  C_TMR_LAST  = TMR_W'(REF_INTERVAL - 1);
    localparam logic [TMR_W-1:0]  C_TMR_ONE   = TMR_W'(1);
    localparam logic [ADDR_W-1:0] C_A10       = ADDR_W'(1024);

    state_t              r_state;
    cmd_t                r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [AREF_W-1:0]   r_aref_n;
    logic [TMR_W-1:0]    r_tmr;
    logic [2:0]          r_pend;
    logic                r_ovf;
    logic                r_init_done;
    logic                r_ref_req;
    logic                r_ref_done;
    logic                r_cmd_own;

    logic                w_tick;
    logic                w_done;
    logic [2:0]          w_pend_next;
    logic                w_ovf_set;

    assign w_tick = r_init_done && (r_tmr == C_TMR_LAST);
    assign w_done = ((r_state == S_RAREF) || (r_state == S_RAREF_W)) && (r_cnt == C_TRFC);

    // A tick and a completion in the same cycle cancel out.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_pend_next = r_pend;
        w_ovf_set   = 1'b0;
        if (w_tick && !w_done) begin
            if (r_pend == 3'd7) w_ovf_set   = 1'b1;
            else                w_pend_next = r_pend + 3'd1;
        end else if (w_done && !w_tick) begin
            w_pend_next = r_pend - 3'd1;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, and the
    // reset branch is on the async edge so outputs drop without a clock.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_state     <= S_WAIT;
            r_cmd       <= CMD_NOP;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_aref_n    <= '0;
            r_tmr       <= '0;
            r_pend      <= 3'd0;
            r_ovf       <= 1'b0;
            r_init_done <= 1'b0;
            r_ref_req   <= 1'b0;
            r_ref_done  <= 1'b0;
            r_cmd_own   <= 1'b1;
        end else begin
            r_cmd      <= CMD_NOP;
            r_addr     <= '0;
            r_ref_done <= 1'b0;
            r_pend     <= w_pend_next;
            if (w_ovf_set) r_ovf <= 1'b1;
            if (r_init_done) r_tmr <= (r_tmr == C_TMR_LAST) ? '0 : r_tmr + C_TMR_ONE;

            case (r_state)
                S_WAIT: begin
                    if (r_cnt == C_INIT_WAIT) begin
                        r_cmd   <= CMD_PRE;
                        r_addr  <= C_A10;
                        r_cnt   <= C_CNT_ONE;
                        r_state <= S_PRE;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                S_PRE, S_PRE_W: begin
                    if (r_cnt == C_TRP) begin
                        r_cmd   <= CMD_REF;
                        r_cnt   <= C_CNT_ONE;
                        r_state <= S_AREF;
                    end else begin
                        r_cnt   <= r_cnt + C_CNT_ONE;
                        r_state <= S_PRE_W;
                    end
                end
                S_AREF, S_AREF_W: begin
                    if (r_cnt == C_TRFC) begin
                        r_cnt <= C_CNT_ONE;
                        if (r_aref_n == C_AREF_LAST) begin
                            r_cmd   <= CMD_MRS;
                            r_addr  <= MODE_REG;
                            r_state <= S_MRS;
                        end else begin
                            r_cmd    <= CMD_REF;
                            r_aref_n <= r_aref_n + C_AREF_ONE;
                            r_state  <= S_AREF;
                        end
                    end else begin
                        r_cnt   <= r_cnt + C_CNT_ONE;
                        r_state <= S_AREF_W;
                    end
                end
                S_MRS, S_MRS_W: begin
                    if (r_cnt == C_TMRD) begin
                        r_init_done <= 1'b1;
                        r_cmd_own   <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + C_CNT_ONE;
                        r_state <= S_MRS_W;
                    end
                end
                // Looks at the next pending value so a tick raises ref_req
                // in the very cycle it lands.
                S_IDLE: begin
                    if (w_pend_next != 3'd0) begin
                        r_ref_req <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ref_gnt) begin
                        r_cmd_own <= 1'b1;
                        r_cmd     <= CMD_PRE;
                        r_addr    <= C_A10;
                        r_cnt     <= C_CNT_ONE;
                        r_state   <= S_RPRE;
                    end
                end
                S_RPRE, S_RPRE_W: begin
                    if (r_cnt == C_TRP) begin
                        r_cmd   <= CMD_REF;
                        r_cnt   <= C_CNT_ONE;
                        r_state <= S_RAREF;
                    end else begin
                        r_cnt   <= r_cnt + C_CNT_ONE;
                        r_state <= S_RPRE_W;
                    end
                end
                // ref_gnt is not consulted here: once started, a refresh
                // always runs to completion.
                S_RAREF, S_RAREF_W: begin
                    if (w_done) begin
                        r_ref_done <= 1'b1;
                        r_ref_req  <= 1'b0;
                        r_cmd_own  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + C_CNT_ONE;
                        r_state <= S_RAREF_W;
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign init_done = r_init_done;
    assign ref_req   = r_ref_req;
    assign ref_done  = r_ref_done;
    assign cmd_own   = r_cmd_own;
    assign sdr_cs_n  = 1'b0;
    assign {sdr_ras_n, sdr_cas_n, sdr_we_n} = r_cmd;
    assign sdr_ba    = 2'b00;
    assign sdr_addr  = r_addr;
    assign ref_ovf   = r_ovf;

endmodule

// File: tb/tb_sdram_init_ref_sched.sv
// -----------------------------------------------------------------------------
// tb_sdram_init_ref_sched
//
// Self-checking bench. A timestamp-based reference model derives, for every
// clock cycle, the full expected output vector from the init timeline, the
// refresh tick schedule and the grant handshake rules; ref_gnt is driven from
// a per-phase policy (low, high, random, or a single aimed pulse).
// -----------------------------------------------------------------------------
module tb_sdram_init_ref_sched;

    localparam int INIT_WAIT = 500;
    localparam int TRP       = 2;
    localparam int TRFC      = 7;
    localparam int TMRD      = 2;
    localparam int NUM_AREF  = 2;
    localparam int RI        = 780;
    localparam int ADDR_W    = 13;
    localparam logic [ADDR_W-1:0] MODE = 13'h033;
    localparam logic [ADDR_W-1:0] A10  = 13'h400;

    localparam int AREF0   = INIT_WAIT + TRP;
    localparam int MRS_AT  = INIT_WAIT + TRP + NUM_AREF * TRFC;
    localparam int DONE_AT = MRS_AT + TMRD;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;

    localparam logic [31:0] RST_VEC = {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CMD_NOP, 2'b00, 13'h0, 1'b0};

    logic              sdram_clk = 1'b0;
    logic              sdram_resetn;
    logic              ref_gnt;
    logic              init_done, ref_req, ref_done, cmd_own;
    logic              sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [1:0]        sdr_ba;
    logic [ADDR_W-1:0] sdr_addr;
    logic              ref_ovf;

    sdram_init_ref_sched #(
        .INIT_WAIT(INIT_WAIT), .TRP(TRP), .TRFC(TRFC), .TMRD(TMRD),
        .NUM_AREF(NUM_AREF), .REF_INTERVAL(RI), .ADDR_W(ADDR_W), .MODE_REG(MODE)
    ) dut (
        .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn), .ref_gnt(ref_gnt),
        .init_done(init_done), .ref_req(ref_req), .ref_done(ref_done),
        .cmd_own(cmd_own), .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n),
        .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n), .sdr_ba(sdr_ba),
        .sdr_addr(sdr_addr), .ref_ovf(ref_ovf)
    );

    always #5 sdram_clk = ~sdram_clk;

    logic [31:0] obs;
    assign obs = {8'h00, init_done, ref_req, ref_done, cmd_own, sdr_cs_n,
                  sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr, ref_ovf};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_n;       // index of the clock edge just taken since reset release
    int          m_pend;
    int          m_pre_at;  // cycle of the refresh PRECHARGE in flight, -1 if none
    bit          m_init, m_req, m_own, m_ovf, m_rdone;
    logic [2:0]  m_cmd;
    logic [12:0] m_addr;

    function automatic void model_reset();
        m_n = -1; m_pend = 0; m_pre_at = -1;
        m_init = 0; m_req = 0; m_own = 1; m_ovf = 0; m_rdone = 0;
        m_cmd = CMD_NOP; m_addr = '0;
    endfunction

    function automatic void model_step(input bit g);
        bit tick, done;
        m_n++;
        m_cmd = CMD_NOP; m_addr = '0; m_rdone = 0;
        if (!m_init) begin
            if (m_n == INIT_WAIT) begin m_cmd = CMD_PRE; m_addr = A10; end
            for (int k = 0; k < NUM_AREF; k++)
                if (m_n == AREF0 + k * TRFC) m_cmd = CMD_REF;
            if (m_n == MRS_AT) begin m_cmd = CMD_MRS; m_addr = MODE; end
            if (m_n == DONE_AT) begin m_init = 1; m_own = 0; end
        end else begin
            tick = ((m_n - DONE_AT) % RI) == 0;
            done = (m_pre_at >= 0) && (m_n == m_pre_at + TRP + TRFC);
            if (tick && !done) begin
                if (m_pend == 7) m_ovf = 1; else m_pend++;
            end else if (done && !tick) begin
                m_pend--;
            end
            if (done) begin
                m_rdone = 1; m_req = 0; m_own = 0; m_pre_at = -1;
            end else if (m_pre_at >= 0) begin
                if (m_n == m_pre_at + TRP) m_cmd = CMD_REF;
            end else if (m_req) begin
                if (g) begin m_pre_at = m_n; m_own = 1; m_cmd = CMD_PRE; m_addr = A10; end
            end else if (m_pend > 0) begin
                m_req = 1;
            end
        end
    endfunction

    function automatic logic [31:0] model_vec();
        return {8'h00, m_init, m_req, m_rdone, m_own, 1'b0, m_cmd, 2'b00, m_addr, m_ovf};
    endfunction

    // ---------------- stimulus ----------------
    int gnt_mode = 0;  // 0 low, 1 high, 2 random, 3 high only for the edge 'aim'
    int aim      = -1;

    // Entered and left at a falling edge.
    task automatic cycle();
        int e;
        bit g;
        e = m_n + 1;
        case (gnt_mode)
            0:       ref_gnt = 1'b0;
            1:       ref_gnt = 1'b1;
            2:       ref_gnt = ($urandom_range(0, 3) == 0);
            default: ref_gnt = (e == aim);
        endcase
        @(posedge sdram_clk);
        g = ref_gnt;
        #1;
        model_step(g);
        check($sformatf("cyc%0d", m_n), obs, model_vec());
        if (m_n == INIT_WAIT && !init_done) check("pre_a10", 32'(sdr_addr[10]), 32'd1);
        if (m_n == MRS_AT && !init_done)    check("mrs_addr", 32'(sdr_addr), 32'(MODE));
        if (m_n == DONE_AT - 1)             check("init_done_low", 32'(init_done), 32'd0);
        @(negedge sdram_clk);
    endtask

    // Entered at a falling edge, so the reset edge is away from any rising edge.
    task automatic do_reset(input string tag);
        sdram_resetn = 1'b0;
        #1;
        check({tag, "_async"}, obs, RST_VEC);
        repeat (2) @(negedge sdram_clk);
        check({tag, "_hold"}, obs, RST_VEC);
        sdram_resetn = 1'b1;
        model_reset();
    endtask

    int t1, t2, pulses, cmds;
    bit seen;

    initial begin
        sdram_resetn = 1'b0;
        ref_gnt      = 1'b0;
        model_reset();
        repeat (2) @(negedge sdram_clk);
        check("rst_init", obs, RST_VEC);
        sdram_resetn = 1'b1;

        // Init with random grant noise, which must be ignored.
        gnt_mode = 2;
        while (m_n < DONE_AT) cycle();
        check("init_done_rise", 32'(init_done), 32'd1);
        check("own_released", 32'(cmd_own), 32'd0);

        // Grant held high: first refresh timing.
        gnt_mode = 1;
        seen = 0;
        repeat (2 * RI + 20) begin
            cycle();
            if (ref_req && !seen) begin
                seen = 1;
                check("first_req_cycle", 32'(m_n), 32'(DONE_AT + RI));
            end
            if (m_n == DONE_AT + RI + 1)  check("pre_after_gnt", 32'({sdr_ras_n, sdr_cas_n, sdr_we_n}), 32'(CMD_PRE));
            if (m_n == DONE_AT + RI + 3)  check("aref_after_pre", 32'({sdr_ras_n, sdr_cas_n, sdr_we_n}), 32'(CMD_REF));
            if (m_n == DONE_AT + RI + 10) check("first_ref_done", 32'({ref_done, ref_req}), 32'b10);
        end

        // Grant low until the counter saturates; stop right after that tick.
        gnt_mode = 0;
        for (int i = 0; i < 9 * RI + 10; i++) begin
            cycle();
            if (m_ovf && ((m_n - DONE_AT) % RI) == 0) break;
        end
        check("ovf_set", 32'(ref_ovf), 32'd1);
        check("req_waiting", 32'(ref_req), 32'd1);

        // Drain: seven back-to-back refreshes.
        gnt_mode = 1;
        pulses = 0;
        repeat (7 * 11 + 20) begin
            cycle();
            if (ref_done) pulses++;
        end
        check("drain_pulses", 32'(pulses), 32'd7);
        check("drain_req_idle", 32'(ref_req), 32'd0);
        check("ovf_sticky", 32'(ref_ovf), 32'd1);

        // Completion lands exactly on a tick with one refresh pending.
        t1 = m_n + 1;
        while (((t1 - DONE_AT) % RI) != 0) t1++;
        t2 = t1 + RI;
        aim = t2 - TRP - TRFC;
        gnt_mode = 3;
        while (m_n < t2 + 1) begin
            cycle();
            if (m_n == t2)     check("coinc_done", 32'({ref_done, ref_req}), 32'b10);
            if (m_n == t2 + 1) check("coinc_rereq", 32'(ref_req), 32'd1);
        end

        // Grant for a single edge, dropped mid-refresh.
        aim = m_n + 1;
        pulses = 0;
        repeat (15) begin
            cycle();
            if (ref_done) pulses++;
        end
        check("drop_mid_done", 32'(pulses), 32'd1);

        // Grant noise with nothing pending: no command may appear.
        gnt_mode = 2;
        cmds = 0;
        repeat (100) begin
            cycle();
            if ({sdr_ras_n, sdr_cas_n, sdr_we_n} != CMD_NOP) cmds++;
        end
        check("idle_gnt_cmds", 32'(cmds), 32'd0);

        // Long random grant phase.
        repeat (2000) cycle();

        // Reset during init at cycle 505, then a full restart.
        do_reset("rst_any");
        while (m_n < 505) cycle();
        do_reset("rst_init505");
        gnt_mode = 1;
        for (int i = 0; i < DONE_AT + RI + 40; i++) begin
            cycle();
            if (m_pre_at >= 0 && m_n == m_pre_at + TRP + 2) break;
        end
        check("own_in_raref_w", 32'(cmd_own), 32'd1);
        do_reset("rst_raref_w");
        gnt_mode = 2;
        repeat (DONE_AT + 50) cycle();
        check("reinit_done", 32'(init_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
